// File: rtl/user_scan_pkg.sv
// Shared types and constants for the user tile scan controller.
// The parity helper is used only when USER_SCAN_PARITY_EN is defined.
package user_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_LATCH   = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_CAPTURE = 3'd4
    } scan_state_t;

    localparam int SCAN_WIDTH_DEF  = 8;
    localparam int SCAN_SETTLE_DEF = 2;

    // Even parity over a zero-extended word: 1 when the number of ones is odd.
    function automatic logic even_parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/user_scan_shift_reg.sv
// Shift / parallel-load register shared by the serial input and output paths.
// Shifts right (LSB leaves first, new bit enters at the MSB). Parallel load wins over shift.
module scan_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_en,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    input  logic         sdi,
    output logic [W-1:0] q
);

    // Register update: reset, parallel capture, or one-bit right shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load_en) begin
            q <= load_val;
        end else if (shift_en) begin
            q <= {sdi, q[W-1:1]};
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/user_scan_ctrl.sv
// Serial scan controller for an 8-in/8-out user tile.
// Shifts a host word in (LSB first) while the previously captured tile output
// shifts out on sdo, applies the word to the tile, waits SETTLE_CYCLES, then
// captures the tile output for the next transaction.
// Optional feature macro: USER_SCAN_PARITY_EN (adds an even-parity bit to the
// serial stream in both directions and a sticky parity_err output).
module user_scan_ctrl
    import user_scan_pkg::*;
#(
    parameter int WIDTH         = SCAN_WIDTH_DEF,
    parameter int SETTLE_CYCLES = SCAN_SETTLE_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sdi,
    output logic             sdo,
    output logic [WIDTH-1:0] module_data_in,
    input  logic [WIDTH-1:0] module_data_out,
    output logic             busy,
`ifdef USER_SCAN_PARITY_EN
    output logic             done,
    output logic             parity_err
`else
    output logic             done
`endif
);

`ifdef USER_SCAN_PARITY_EN
    // The parity bit rides as an extra MSB of the shift register so that it
    // follows the data word on sdo and lands in the top bit on the way in.
    localparam int SR_W      = WIDTH + 1;
`else
    localparam int SR_W      = WIDTH;
`endif
    localparam int SHIFT_LEN = SR_W;
    localparam int BCW       = $clog2(WIDTH + 1);

    scan_state_t        state_q;
    logic [BCW-1:0]     bit_cnt_q;
    logic [3:0]         settle_cnt_q;
    logic [WIDTH-1:0]   data_in_q;
    logic               busy_q;
    logic               done_q;
`ifdef USER_SCAN_PARITY_EN
    logic               parity_err_q;
`endif

    logic [SR_W-1:0]    shreg_s;
    logic [SR_W-1:0]    load_val_s;
    logic               shift_en_s;
    logic               load_en_s;

    // Shift-register control decoded from the current state.
    always_comb begin
        shift_en_s = (state_q == ST_SHIFT);
        load_en_s  = (state_q == ST_CAPTURE);
`ifdef USER_SCAN_PARITY_EN
        load_val_s = {even_parity(32'(module_data_out)), module_data_out};
`else
        load_val_s = module_data_out;
`endif
    end

    scan_shift_reg #(
        .W (SR_W)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en_s),
        .load_en  (load_en_s),
        .load_val (load_val_s),
        .sdi      (sdi),
        .q        (shreg_s)
    );

    // Transaction sequencer: state, bit/settle counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            settle_cnt_q <= 4'd0;
            data_in_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef USER_SCAN_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q   <= ST_SHIFT;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
`ifdef USER_SCAN_PARITY_EN
                        parity_err_q <= 1'b0;
`endif
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_q == BCW'(SHIFT_LEN - 1)) begin
                        state_q   <= ST_LATCH;
                        bit_cnt_q <= '0;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + BCW'(1);
                    end
                end
                ST_LATCH: begin
`ifdef USER_SCAN_PARITY_EN
                    // A corrupted word never reaches the tile.
                    if (^shreg_s) begin
                        parity_err_q <= 1'b1;
                    end else begin
                        data_in_q <= shreg_s[WIDTH-1:0];
                    end
`else
                    data_in_q <= shreg_s;
`endif
                    settle_cnt_q <= 4'(SETTLE_CYCLES);
                    state_q      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_q <= 4'd1) begin
                        settle_cnt_q <= 4'd0;
                        state_q      <= ST_CAPTURE;
                        done_q       <= 1'b1;
                    end else begin
                        settle_cnt_q <= settle_cnt_q - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    bit_cnt_q    <= '0;
                    settle_cnt_q <= 4'd0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b0;
                end
            endcase
        end
    end

    assign sdo            = shreg_s[0];
    assign module_data_in = data_in_q;
    assign busy           = busy_q;
    assign done           = done_q;
`ifdef USER_SCAN_PARITY_EN
    assign parity_err     = parity_err_q;
`endif

endmodule

// File: tb/tb_user_scan_ctrl.sv
// Scoreboard bench for user_scan_ctrl: a driver issues random scan
// transactions and queues the expected results; a monitor watches busy/done/sdo
// and compares each completed transaction against the queue.
module tb_user_scan_ctrl;

    localparam int W      = 8;
    localparam int SETTLE = 2;
`ifdef USER_SCAN_PARITY_EN
    localparam int SLEN   = W + 1;
`else
    localparam int SLEN   = W;
`endif
    localparam int DONE_CYC = SLEN + 2 + SETTLE;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         sdi;
    logic         sdo;
    logic [W-1:0] mdi;
    logic [W-1:0] mdo;
    logic         busy;
    logic         done;
    logic         perr;

    int checks   = 0;
    int failures = 0;
    int issued   = 0;
    int dones    = 0;

    typedef struct packed {
        logic [7:0]  mdi;
        logic [15:0] sdo;
        logic        perr;
    } exp_t;
    exp_t exp_q[$];

    // Reference state: word currently applied to the tile and word last captured.
    logic [7:0] model_mdi = 8'h00;
    logic [7:0] model_cap = 8'h00;

    // Tile model.
    assign mdo = {mdi[7:4], ~mdi[3:0]};

    always #5 clk = ~clk;

`ifdef USER_SCAN_PARITY_EN
    user_scan_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .sdi(sdi), .sdo(sdo),
        .module_data_in(mdi), .module_data_out(mdo), .busy(busy), .done(done),
        .parity_err(perr)
    );
`else
    user_scan_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .sdi(sdi), .sdo(sdo),
        .module_data_in(mdi), .module_data_out(mdo), .busy(busy), .done(done)
    );
    assign perr = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ones_odd(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(v[i]);
        return (n % 2) == 1;
    endfunction

    // Issue one transaction. Called #1 after a rising edge while DUT is idle.
    task automatic do_txn(input logic [7:0] d, input bit bad_par, input bit hold, input int pulse_at);
        exp_t e;
        logic [15:0] stream;
        logic        ok;
        stream = {8'h00, d};
        ok = 1'b1;
`ifdef USER_SCAN_PARITY_EN
        stream[8] = ones_odd(d) ^ bad_par;
        ok = !bad_par;
`endif
        e.mdi  = ok ? d : model_mdi;
        e.perr = !ok;
        e.sdo  = {8'h00, model_cap};
`ifdef USER_SCAN_PARITY_EN
        e.sdo[8] = ones_odd(model_cap);
`endif
        exp_q.push_back(e);
        issued++;
        model_mdi = e.mdi;
        model_cap = {e.mdi[7:4], ~e.mdi[3:0]};

        start = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < SLEN; k++) begin
            sdi   = stream[k];
            start = hold || (k + 1 == pulse_at);
            @(posedge clk); #1;
        end
        start = hold;
        sdi   = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        chk("txn_end_idle", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: tracks cycles from busy rising, collects sdo, scores each done.
    int         cyc = 0;
    logic       busy_prev = 1'b0;
    logic [15:0] sdo_w = 16'h0;
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            cyc = 0;
        end else if (busy && !busy_prev) begin
            cyc = 1;
            sdo_w = 16'h0;
        end else if (busy) begin
            cyc++;
        end
        if (!reset && busy && cyc >= 1 && cyc <= SLEN) sdo_w[cyc-1] = sdo;
        if (!reset && busy && cyc == SLEN + 2 && exp_q.size() > 0)
            chk("mdi_after_latch", {24'd0, mdi}, {24'd0, exp_q[0].mdi});
        if (!reset && busy && cyc > 40) begin
            chk("done_timeout", cyc, DONE_CYC);
            cyc = 0;
        end
        if (done) begin
            dones++;
            chk("done_cycle", cyc, DONE_CYC);
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("mdi_at_done", {24'd0, mdi}, {24'd0, e.mdi});
                chk("sdo_word", {16'd0, sdo_w}, {16'd0, e.sdo});
                chk("parity_err", {31'd0, perr}, {31'd0, e.perr});
            end
        end
        busy_prev = busy;
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        sdi   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_mdi", {24'd0, mdi}, 32'd0);
        chk("rst_sdo", {31'd0, sdo}, 32'd0);
        chk("rst_perr", {31'd0, perr}, 32'd0);
        @(posedge clk); #1;

        // 0xA5, then a follow-up that must shift 0xAA out.
        do_txn(8'hA5, 1'b0, 1'b0, 0);
        chk("sdo_idle_lsb", {31'd0, sdo}, 32'd0);
        do_txn(8'h5A, 1'b0, 1'b0, 0);

        // Back-to-back with start held high: 0x00 then 0xFF (sdo returns 0x0F).
        do_txn(8'h00, 1'b0, 1'b1, 0);
        do_txn(8'hFF, 1'b0, 1'b0, 0);

        // start pulse during SHIFT is ignored.
        do_txn(8'h96, 1'b0, 1'b0, 5);
        repeat (3) @(posedge clk); #1;
        chk("no_extra_busy", {31'd0, busy}, 32'd0);

        // Reset during shift of 0x3C aborts the transaction.
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sdi = 1'(8'h3C >> k);
            if (k == 5) reset = 1'b1;
            @(posedge clk); #1;
        end
        reset = 1'b0;
        sdi   = 1'b0;
        model_mdi = 8'h00;
        model_cap = 8'h00;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_mdi", {24'd0, mdi}, 32'd0);
        chk("abort_sdo", {31'd0, sdo}, 32'd0);
        @(posedge clk); #1;

`ifdef USER_SCAN_PARITY_EN
        // 0x01 with parity bit 0 is rejected.
        do_txn(8'h01, 1'b1, 1'b0, 0);
`endif

        // Randomised traffic.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] d;
            bit         h;
            d = 8'($urandom_range(255, 0));
            h = ($urandom_range(3, 0) == 0) && (n != 23);
            do_txn(d, bit'($urandom_range(3, 0) == 0), h,
                   ($urandom_range(1, 0) == 1) ? int'($urandom_range(SLEN, 1)) : 0);
        end
        start = 1'b0;
        repeat (5) @(posedge clk); #1;

        chk("queue_empty", exp_q.size(), 32'd0);
        chk("done_count", dones, issued);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
